// File: rtl/mem_pkg.sv
// Shared types and constants for the line-granular memory responder and its cache-side peer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    // Responder state: waiting for a request, counting down latency, presenting gnt.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default line geometry: 2**3 words of 32 bits per line.
    localparam int LINE_SIZE = 8;

    // Latency counter width, sized for the largest supported latency (1023).
    localparam int CNT_W = $clog2(1024);

    // Line as seen by the cache controller: LINE_SIZE words, word i at index i.
    typedef logic [31:0] line_t [LINE_SIZE];

endpackage

// File: rtl/line_mem_array.sv
// Line storage: 2**ADDR_LEN lines, one synchronous write port, one registered read port.
// Latency: write visible to a read on the following edge; read data valid the cycle after rd_en.
// Backpressure: none; every enabled access completes on its edge.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears only the read register)
//   wr_en/wr_addr/wr_dat write one full line
//   rd_en/rd_addr       load rd_dat from the addressed line
//   rd_dat              registered read data, held until the next rd_en
module line_mem_array #(
    parameter int ADDR_LEN = 10,
    parameter int LINE_W   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [LINE_W-1:0]   wr_dat,
    input  logic                rd_en,
    input  logic [ADDR_LEN-1:0] rd_addr,
    output logic [LINE_W-1:0]   rd_dat
);

    // Contents are deliberately left untouched by reset.
    logic [LINE_W-1:0] mem [2**ADDR_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Slow main-memory responder: accepts one line read/write, waits LATENCY cycles, commits, pulses gnt.
// Latency: request accepted at edge k -> gnt high in cycle [k+LATENCY, k+LATENCY+1); period LATENCY+1.
// Backpressure: requests are held by the requester until gnt; none is taken while BUSY.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   addr                line address of the request
//   rd_req / wr_req     line read / line write request (write wins if both are high)
//   wr_line             write data, word i of the line at index i
//   rd_line             registered read data, changes only on a read commit
//   gnt                 one-cycle completion pulse
//   rd_count / wr_count completed reads / writes since reset, wrapping
module line_mem_responder
    import mem_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int LATENCY       = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [31:0]         wr_line [2**LINE_ADDR_LEN],
    output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
    output logic                gnt,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);

    localparam int LINE_WORDS = 2**LINE_ADDR_LEN;
    localparam int LINE_W     = 32 * LINE_WORDS;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                commit;

    logic [ADDR_LEN-1:0] addr_q;
    logic                op_wr_q;
    logic [LINE_W-1:0]   wr_dat_q;

    logic [LINE_W-1:0]   wr_line_flat;
    logic [LINE_W-1:0]   rd_dat;

    // Lines travel through the array as flat vectors; word i occupies bits [32*i +: 32].
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_words
        assign wr_line_flat[32*i +: 32] = wr_line[i];
        assign rd_line[i]               = rd_dat[32*i +: 32];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // gnt is high this cycle. The requester lowers its old request on the
                // edge where it sees gnt, so anything still high here is the follow-up
                // transaction (e.g. the fill after a write-back) and is taken at once.
                if (rd_req || wr_req) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, latency counter, gnt and completion counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            gnt      <= 1'b0;
            addr_q   <= '0;
            op_wr_q  <= 1'b0;
            wr_dat_q <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            gnt <= commit;
            if (accept) begin
                // Snapshot everything; later changes on the request inputs are ignored.
                addr_q   <= addr;
                op_wr_q  <= wr_req;
                wr_dat_q <= wr_line_flat;
                cnt      <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                if (op_wr_q) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset on the commit edge must suppress the array write, so the
    // write enable is qualified with rst_n; the read register resets itself.
    // ------------------------------------------------------------------
    logic arr_wr_en;
    logic arr_rd_en;

    assign arr_wr_en = commit &&  op_wr_q && rst_n;
    assign arr_rd_en = commit && !op_wr_q;

    line_mem_array #(
        .ADDR_LEN (ADDR_LEN),
        .LINE_W   (LINE_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arr_wr_en),
        .wr_addr (addr_q),
        .wr_dat  (wr_dat_q),
        .rd_en   (arr_rd_en),
        .rd_addr (addr_q),
        .rd_dat  (rd_dat)
    );

endmodule
